// File: rtl/ex_branch_redirect.sv
// Branch port 0 redirect sequencer: captures one redirect event, waits for its tag to
// retire, pulses the pipeline restart, then hands the target to fetch.
module ex_branch_redirect #(
    parameter int P_SWI_VECT_SHIFT = 2,
    parameter int P_FLUSH_CYCLES   = 2
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iJUMP_ACTIVE,
    input  logic [31:0] iJUMP_ADDR,
    input  logic        iSWI_ACTIVE,
    input  logic [10:0] iSWI_NUMBER,
    input  logic        iINTR_ACTIVE,
    input  logic [31:0] iINTR_ADDR,
    input  logic        iIDTS_ACTIVE,
    input  logic [31:0] iIDTS_R_ADDR,
    input  logic [5:0]  iIDTR_COMMIT_TAG,
    input  logic [31:0] iSWI_VECTOR_BASE,
    input  logic        iCOMMIT_VALID,
    input  logic [5:0]  iCOMMIT_TAG,
    input  logic        iEXCEPT_FLUSH,
    output logic        oFREE_RESTART,
    output logic        oFETCH_REDIRECT_VALID,
    output logic [31:0] oFETCH_REDIRECT_ADDR,
    input  logic        iFETCH_REDIRECT_READY,
    output logic        oBUSY
);

    typedef enum logic [1:0] {IDLE, WAIT_COMMIT, FLUSH, REDIRECT} stateT;

    localparam logic [3:0] FLUSH_LAST = 4'(P_FLUSH_CYCLES - 1);

    stateT       state, stateNext;
    logic [5:0]  latTag, latTagNext;
    logic [31:0] latAddr, latAddrNext;
    logic [3:0]  flushCnt, flushCntNext;

    logic        anyEvent;
    logic [31:0] swiTarget;
    logic [31:0] evTarget;

    assign anyEvent  = iJUMP_ACTIVE | iSWI_ACTIVE | iINTR_ACTIVE | iIDTS_ACTIVE;
    // Vector offset wraps modulo 2^32 together with the base.
    assign swiTarget = iSWI_VECTOR_BASE + ({21'b0, iSWI_NUMBER} << P_SWI_VECT_SHIFT);

    always_comb begin
        evTarget = iJUMP_ADDR;
        if (iINTR_ACTIVE)      evTarget = iINTR_ADDR;
        else if (iIDTS_ACTIVE) evTarget = iIDTS_R_ADDR;
        else if (iSWI_ACTIVE)  evTarget = swiTarget;
    end

    always_comb begin
        stateNext    = state;
        latTagNext   = latTag;
        latAddrNext  = latAddr;
        flushCntNext = flushCnt;
        unique case (state)
            IDLE: begin
                if (anyEvent && !iEXCEPT_FLUSH) begin
                    latTagNext   = iIDTR_COMMIT_TAG;
                    latAddrNext  = evTarget;
                    flushCntNext = '0;
                    stateNext    = (iCOMMIT_VALID && iCOMMIT_TAG == iIDTR_COMMIT_TAG)
                                   ? FLUSH : WAIT_COMMIT;
                end
            end
            WAIT_COMMIT: begin
                if (iEXCEPT_FLUSH) begin
                    stateNext = IDLE;
                end else if (iCOMMIT_VALID && iCOMMIT_TAG == latTag) begin
                    flushCntNext = '0;
                    stateNext    = FLUSH;
                end
            end
            FLUSH: begin
                if (iEXCEPT_FLUSH) begin
                    flushCntNext = '0;
                    stateNext    = IDLE;
                end else if (flushCnt == FLUSH_LAST) begin
                    flushCntNext = '0;
                    stateNext    = REDIRECT;
                end else begin
                    flushCntNext = flushCnt + 4'd1;
                end
            end
            REDIRECT: begin
                // The exception flush cannot cancel a redirect already offered to fetch.
                if (iFETCH_REDIRECT_READY) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state    <= IDLE;
            latTag   <= '0;
            latAddr  <= '0;
            flushCnt <= '0;
        end else begin
            state    <= stateNext;
            latTag   <= latTagNext;
            latAddr  <= latAddrNext;
            flushCnt <= flushCntNext;
        end
    end

    assign oFREE_RESTART         = (state == FLUSH);
    assign oFETCH_REDIRECT_VALID = (state == REDIRECT);
    assign oFETCH_REDIRECT_ADDR  = (state == REDIRECT) ? latAddr : 32'h0;
    assign oBUSY                 = (state != IDLE);

endmodule

// File: tb/tb_ex_branch_redirect.sv
// Directed bench for ex_branch_redirect: each task drives one scenario and checks
// outputs 1 time unit after driving, i.e. mid-cycle.
module tb_ex_branch_redirect;

    logic        iCLOCK = 1'b0;
    logic        iRESET;
    logic        iJUMP_ACTIVE;
    logic [31:0] iJUMP_ADDR;
    logic        iSWI_ACTIVE;
    logic [10:0] iSWI_NUMBER;
    logic        iINTR_ACTIVE;
    logic [31:0] iINTR_ADDR;
    logic        iIDTS_ACTIVE;
    logic [31:0] iIDTS_R_ADDR;
    logic [5:0]  iIDTR_COMMIT_TAG;
    logic [31:0] iSWI_VECTOR_BASE;
    logic        iCOMMIT_VALID;
    logic [5:0]  iCOMMIT_TAG;
    logic        iEXCEPT_FLUSH;
    logic        oFREE_RESTART;
    logic        oFETCH_REDIRECT_VALID;
    logic [31:0] oFETCH_REDIRECT_ADDR;
    logic        iFETCH_REDIRECT_READY;
    logic        oBUSY;

    int checks = 0;
    int failures = 0;

    ex_branch_redirect #(.P_SWI_VECT_SHIFT(2), .P_FLUSH_CYCLES(2)) dut (
        .iCLOCK(iCLOCK), .iRESET(iRESET),
        .iJUMP_ACTIVE(iJUMP_ACTIVE), .iJUMP_ADDR(iJUMP_ADDR),
        .iSWI_ACTIVE(iSWI_ACTIVE), .iSWI_NUMBER(iSWI_NUMBER),
        .iINTR_ACTIVE(iINTR_ACTIVE), .iINTR_ADDR(iINTR_ADDR),
        .iIDTS_ACTIVE(iIDTS_ACTIVE), .iIDTS_R_ADDR(iIDTS_R_ADDR),
        .iIDTR_COMMIT_TAG(iIDTR_COMMIT_TAG), .iSWI_VECTOR_BASE(iSWI_VECTOR_BASE),
        .iCOMMIT_VALID(iCOMMIT_VALID), .iCOMMIT_TAG(iCOMMIT_TAG),
        .iEXCEPT_FLUSH(iEXCEPT_FLUSH),
        .oFREE_RESTART(oFREE_RESTART),
        .oFETCH_REDIRECT_VALID(oFETCH_REDIRECT_VALID),
        .oFETCH_REDIRECT_ADDR(oFETCH_REDIRECT_ADDR),
        .iFETCH_REDIRECT_READY(iFETCH_REDIRECT_READY),
        .oBUSY(oBUSY)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic clearInputs();
        iJUMP_ACTIVE = 0; iJUMP_ADDR = 0; iSWI_ACTIVE = 0; iSWI_NUMBER = 0;
        iINTR_ACTIVE = 0; iINTR_ADDR = 0; iIDTS_ACTIVE = 0; iIDTS_R_ADDR = 0;
        iIDTR_COMMIT_TAG = 0; iSWI_VECTOR_BASE = 0; iCOMMIT_VALID = 0; iCOMMIT_TAG = 0;
        iEXCEPT_FLUSH = 0; iFETCH_REDIRECT_READY = 0;
    endtask

    task automatic test_reset();
        iRESET = 1; clearInputs(); #1;
        checks++; if (oFREE_RESTART !== 1'b0) begin failures++; $display("FAIL reset_restart got=%0b exp=0", oFREE_RESTART); end
        checks++; if (oFETCH_REDIRECT_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", oFETCH_REDIRECT_VALID); end
        checks++; if (oFETCH_REDIRECT_ADDR !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", oFETCH_REDIRECT_ADDR); end
        checks++; if (oBUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", oBUSY); end
        tick(); tick(); iRESET = 0; tick();
        checks++; if (oBUSY !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%0b exp=0", oBUSY); end
    endtask

    task automatic test_jump();
        iJUMP_ACTIVE = 1; iJUMP_ADDR = 32'h0000_1000; iIDTR_COMMIT_TAG = 6'd5; #1;
        checks++; if (oBUSY !== 1'b0) begin failures++; $display("FAIL jump_idle_busy got=%0b exp=0", oBUSY); end
        tick(); clearInputs(); #1;
        checks++; if (oBUSY !== 1'b1) begin failures++; $display("FAIL jump_wait_busy got=%0b exp=1", oBUSY); end
        checks++; if (oFREE_RESTART !== 1'b0) begin failures++; $display("FAIL jump_wait_restart got=%0b exp=0", oFREE_RESTART); end
        tick(); iCOMMIT_VALID = 1; iCOMMIT_TAG = 6'd5; #1;
        checks++; if (oFREE_RESTART !== 1'b0) begin failures++; $display("FAIL jump_commit_restart got=%0b exp=0", oFREE_RESTART); end
        tick(); clearInputs(); #1;
        checks++; if (oFREE_RESTART !== 1'b1) begin failures++; $display("FAIL jump_flush1 got=%0b exp=1", oFREE_RESTART); end
        checks++; if (oFETCH_REDIRECT_VALID !== 1'b0) begin failures++; $display("FAIL jump_flush1_valid got=%0b exp=0", oFETCH_REDIRECT_VALID); end
        tick(); #1;
        checks++; if (oFREE_RESTART !== 1'b1) begin failures++; $display("FAIL jump_flush2 got=%0b exp=1", oFREE_RESTART); end
        tick(); iFETCH_REDIRECT_READY = 1; #1;
        checks++; if (oFREE_RESTART !== 1'b0) begin failures++; $display("FAIL jump_redir_restart got=%0b exp=0", oFREE_RESTART); end
        checks++; if (oFETCH_REDIRECT_VALID !== 1'b1) begin failures++; $display("FAIL jump_redir_valid got=%0b exp=1", oFETCH_REDIRECT_VALID); end
        checks++; if (oFETCH_REDIRECT_ADDR !== 32'h0000_1000) begin failures++; $display("FAIL jump_redir_addr got=%h exp=00001000", oFETCH_REDIRECT_ADDR); end
        tick(); clearInputs(); #1;
        checks++; if (oFETCH_REDIRECT_VALID !== 1'b0) begin failures++; $display("FAIL jump_done_valid got=%0b exp=0", oFETCH_REDIRECT_VALID); end
        checks++; if (oBUSY !== 1'b0) begin failures++; $display("FAIL jump_done_busy got=%0b exp=0", oBUSY); end
    endtask

    // SWI with the tag retiring in the capture cycle, then fetch back-pressure.
    task automatic test_swi_backpressure();
        tick();
        iSWI_ACTIVE = 1; iSWI_NUMBER = 11'h7FF; iSWI_VECTOR_BASE = 32'hFFFF_F000;
        iIDTR_COMMIT_TAG = 6'd6; iCOMMIT_VALID = 1; iCOMMIT_TAG = 6'd6;
        tick(); clearInputs(); #1;
        checks++; if (oFREE_RESTART !== 1'b1) begin failures++; $display("FAIL swi_flush1 got=%0b exp=1", oFREE_RESTART); end
        tick(); #1;
        checks++; if (oFREE_RESTART !== 1'b1) begin failures++; $display("FAIL swi_flush2 got=%0b exp=1", oFREE_RESTART); end
        for (int i = 0; i < 3; i++) begin
            tick(); iEXCEPT_FLUSH = (i == 1); #1;
            checks++; if (oFETCH_REDIRECT_VALID !== 1'b1) begin failures++; $display("FAIL swi_stall_valid[%0d] got=%0b exp=1", i, oFETCH_REDIRECT_VALID); end
            checks++; if (oFETCH_REDIRECT_ADDR !== 32'h0000_0FFC) begin failures++; $display("FAIL swi_stall_addr[%0d] got=%h exp=00000ffc", i, oFETCH_REDIRECT_ADDR); end
            checks++; if (oFREE_RESTART !== 1'b0) begin failures++; $display("FAIL swi_stall_restart[%0d] got=%0b exp=0", i, oFREE_RESTART); end
        end
        tick(); iEXCEPT_FLUSH = 0; iFETCH_REDIRECT_READY = 1; #1;
        checks++; if (oFETCH_REDIRECT_ADDR !== 32'h0000_0FFC) begin failures++; $display("FAIL swi_accept_addr got=%h exp=00000ffc", oFETCH_REDIRECT_ADDR); end
        tick(); clearInputs(); #1;
        checks++; if (oBUSY !== 1'b0) begin failures++; $display("FAIL swi_done_busy got=%0b exp=0", oBUSY); end
    endtask

    task automatic test_priority_lock();
        tick();
        iINTR_ACTIVE = 1; iINTR_ADDR = 32'h0000_2000;
        iJUMP_ACTIVE = 1; iJUMP_ADDR = 32'h0000_3000; iIDTR_COMMIT_TAG = 6'd2;
        tick(); clearInputs();
        iJUMP_ACTIVE = 1; iJUMP_ADDR = 32'h0000_4444; iIDTR_COMMIT_TAG = 6'd7; #1;
        checks++; if (oBUSY !== 1'b1) begin failures++; $display("FAIL prio_wait_busy got=%0b exp=1", oBUSY); end
        tick(); clearInputs(); iCOMMIT_VALID = 1; iCOMMIT_TAG = 6'd7;
        tick(); clearInputs(); #1;
        checks++; if (oFREE_RESTART !== 1'b0) begin failures++; $display("FAIL prio_second_jump_restart got=%0b exp=0", oFREE_RESTART); end
        iCOMMIT_VALID = 1; iCOMMIT_TAG = 6'd2;
        tick(); clearInputs(); #1;
        checks++; if (oFREE_RESTART !== 1'b1) begin failures++; $display("FAIL prio_flush1 got=%0b exp=1", oFREE_RESTART); end
        tick(); tick(); iFETCH_REDIRECT_READY = 1; #1;
        checks++; if (oFETCH_REDIRECT_ADDR !== 32'h0000_2000) begin failures++; $display("FAIL prio_addr got=%h exp=00002000", oFETCH_REDIRECT_ADDR); end
        tick(); clearInputs();
    endtask

    task automatic test_tag_match();
        tick(); iJUMP_ACTIVE = 1; iJUMP_ADDR = 32'h0000_0600; iIDTR_COMMIT_TAG = 6'd6;
        tick(); clearInputs(); iCOMMIT_VALID = 1; iCOMMIT_TAG = 6'd3;
        tick(); iCOMMIT_TAG = 6'd4; #1;
        checks++; if (oFREE_RESTART !== 1'b0) begin failures++; $display("FAIL tag3_restart got=%0b exp=0", oFREE_RESTART); end
        tick(); iCOMMIT_TAG = 6'd6; #1;
        checks++; if (oFREE_RESTART !== 1'b0) begin failures++; $display("FAIL tag4_restart got=%0b exp=0", oFREE_RESTART); end
        checks++; if (oBUSY !== 1'b1) begin failures++; $display("FAIL tag4_busy got=%0b exp=1", oBUSY); end
        tick(); clearInputs(); #1;
        checks++; if (oFREE_RESTART !== 1'b1) begin failures++; $display("FAIL tag6_restart got=%0b exp=1", oFREE_RESTART); end
        tick(); tick(); iFETCH_REDIRECT_READY = 1; #1;
        checks++; if (oFETCH_REDIRECT_ADDR !== 32'h0000_0600) begin failures++; $display("FAIL tag6_addr got=%h exp=00000600", oFETCH_REDIRECT_ADDR); end
        tick(); clearInputs();
    endtask

    task automatic test_except_flush();
        tick(); iJUMP_ACTIVE = 1; iJUMP_ADDR = 32'h0000_0700; iIDTR_COMMIT_TAG = 6'd9;
        iCOMMIT_VALID = 1; iCOMMIT_TAG = 6'd9;
        tick(); clearInputs(); iEXCEPT_FLUSH = 1; #1;
        checks++; if (oFREE_RESTART !== 1'b1) begin failures++; $display("FAIL exc_flush1_restart got=%0b exp=1", oFREE_RESTART); end
        tick(); iEXCEPT_FLUSH = 0; #1;
        checks++; if (oFREE_RESTART !== 1'b0) begin failures++; $display("FAIL exc_restart_len got=%0b exp=0", oFREE_RESTART); end
        checks++; if (oBUSY !== 1'b0) begin failures++; $display("FAIL exc_busy got=%0b exp=0", oBUSY); end
        tick(); tick(); #1;
        checks++; if (oFETCH_REDIRECT_VALID !== 1'b0) begin failures++; $display("FAIL exc_no_redirect got=%0b exp=0", oFETCH_REDIRECT_VALID); end
        // Cancel from WAIT_COMMIT, then check that a flush in IDLE blocks capture.
        iJUMP_ACTIVE = 1; iIDTR_COMMIT_TAG = 6'd10;
        tick(); clearInputs(); iEXCEPT_FLUSH = 1;
        tick(); iEXCEPT_FLUSH = 0; #1;
        checks++; if (oBUSY !== 1'b0) begin failures++; $display("FAIL exc_wait_cancel got=%0b exp=0", oBUSY); end
        iJUMP_ACTIVE = 1; iEXCEPT_FLUSH = 1;
        tick(); clearInputs(); #1;
        checks++; if (oBUSY !== 1'b0) begin failures++; $display("FAIL exc_idle_block got=%0b exp=0", oBUSY); end
    endtask

    task automatic test_reset_mid();
        tick(); iIDTS_ACTIVE = 1; iIDTS_R_ADDR = 32'h0000_0804; iIDTR_COMMIT_TAG = 6'd11;
        tick(); clearInputs(); #1;
        checks++; if (oBUSY !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%0b exp=1", oBUSY); end
        iRESET = 1; #1;
        checks++; if (oBUSY !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", oBUSY); end
        checks++; if (oFREE_RESTART !== 1'b0 || oFETCH_REDIRECT_VALID !== 1'b0 || oFETCH_REDIRECT_ADDR !== 32'h0) begin
            failures++; $display("FAIL rstmid_outputs got=%0b/%0b/%h exp=0/0/0", oFREE_RESTART, oFETCH_REDIRECT_VALID, oFETCH_REDIRECT_ADDR);
        end
        tick(); iRESET = 0; iCOMMIT_VALID = 1; iCOMMIT_TAG = 6'd11;
        tick(); clearInputs(); #1;
        checks++; if (oFREE_RESTART !== 1'b0) begin failures++; $display("FAIL rstmid_stale_commit got=%0b exp=0", oFREE_RESTART); end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_swi_backpressure();
        test_priority_lock();
        test_tag_match();
        test_except_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
